// File: rtl/ysyx_22040729_ifu_pkg.sv
// Shared fetch/decode definitions: FSM encoding, the NOP filler, and the
// width and reset-PC defaults that the decoder also uses.
package ysyx_22040729_ifu_pkg;

    localparam int          INST_WIDTH_DEF = 32;
    localparam int          ADDR_WIDTH_DEF = 64;
    localparam logic [63:0] RESET_PC_DEF   = 64'h8000_0000;
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22040729_ifu.sv
// Instruction fetch unit: one outstanding imem fetch at a time, the result is
// held for the decoder until it is accepted or a redirect squashes it.
module ysyx_22040729_ifu
    import ysyx_22040729_ifu_pkg::*;
#(
    parameter int                    INST_WIDTH = INST_WIDTH_DEF,
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_fault
);

    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  kill_q, kill_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [INST_WIDTH-1:0] instruction_q, instruction_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  inst_fault_q, inst_fault_d;

    logic misaligned;
    logic req_fire;

    // A misaligned PC never reaches memory; it turns into a faulting NOP instead.
    assign misaligned     = (pc_q[1:0] != 2'b00);
    assign imem_req_valid = (state_q == ST_REQ) && rst_n && !misaligned;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        kill_d        = kill_q;
        inst_valid_d  = inst_valid_q;
        instruction_d = instruction_q;
        inst_pc_d     = inst_pc_q;
        inst_fault_d  = inst_fault_q;

        case (state_q)
            ST_REQ: begin
                if (redirect_valid) begin
                    // The old-PC request may still be taken; its response is then stale.
                    pc_d = redirect_pc;
                    if (req_fire) begin
                        kill_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end else if (misaligned) begin
                    instruction_d = INST_WIDTH'(NOP_INST);
                    inst_fault_d  = 1'b1;
                    inst_pc_d     = pc_q;
                    inst_valid_d  = 1'b1;
                    state_d       = ST_HOLD;
                end else if (req_fire) begin
                    kill_d  = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_rsp_valid) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        instruction_d = imem_rsp_data;
                        inst_pc_d     = pc_q;
                        inst_fault_d  = imem_rsp_err;
                        inst_valid_d  = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    inst_valid_d = 1'b0;
                    pc_d         = redirect_pc;
                    state_d      = ST_REQ;
                end else if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    pc_d         = pc_q + ADDR_WIDTH'(4);
                    state_d      = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_REQ;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            inst_valid_q  <= 1'b0;
            instruction_q <= '0;
            inst_pc_q     <= '0;
            inst_fault_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            inst_valid_q  <= inst_valid_d;
            instruction_q <= instruction_d;
            inst_pc_q     <= inst_pc_d;
            inst_fault_q  <= inst_fault_d;
        end
    end

    assign inst_valid  = inst_valid_q;
    assign instruction = instruction_q;
    assign inst_pc     = inst_pc_q;
    assign inst_fault  = inst_fault_q;

endmodule

// File: tb/tb_ysyx_22040729_ifu.sv
// Directed bench for the fetch unit with a small latency-programmable imem model.
module tb_ysyx_22040729_ifu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [63:0] inst_pc;
    logic        inst_fault;

    int n_cmp = 0;
    int n_err = 0;

    // memory model state
    int          mem_lat  = 1;
    logic [31:0] mem_data = 32'h0;
    logic        mem_err  = 1'b0;
    bit          pending  = 1'b0;
    int          cnt      = 0;
    int          n_fire   = 0;

    logic [31:0] hold_instr;
    logic [63:0] hold_pc;

    always #5 clk = ~clk;

    ysyx_22040729_ifu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: the memory sees what fires at this edge, then drives the next cycle.
    task automatic step();
        bit fire;
        bit rsp_now;
        fire    = imem_req_valid && imem_req_ready;
        rsp_now = imem_rsp_valid;
        @(posedge clk);
        #1;
        if (rsp_now) pending = 1'b0;
        if (fire) begin
            n_cmp++;
            assert (!pending) else begin
                n_err++;
                $error("FAIL one_outstanding: observed %0d expected %0d", 2, 1);
            end
            pending = 1'b1;
            cnt     = mem_lat;
            n_fire++;
        end
        if (!rst_n) pending = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        if (pending) begin
            if (cnt == 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data;
                imem_rsp_err   = mem_err;
            end else begin
                cnt--;
            end
        end
    endtask

    initial begin
        int fires0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        mem_data       = 32'h0000_0093;

        // reset state
        step();
        step();
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_instruction", 64'(instruction), 64'd0);
        chk("rst_inst_pc", inst_pc, 64'd0);
        chk("rst_inst_fault", 64'(inst_fault), 64'd0);
        rst_n = 1'b1;
        #1;

        // basic fetch, 1-cycle latency
        chk("c1_req_valid", 64'(imem_req_valid), 64'd1);
        chk("c1_req_addr", imem_req_addr, 64'h8000_0000);
        step();
        chk("c2_inst_valid", 64'(inst_valid), 64'd0);
        chk("c2_req_valid", 64'(imem_req_valid), 64'd0);
        step();
        chk("c3_inst_valid", 64'(inst_valid), 64'd1);
        chk("c3_instruction", 64'(instruction), 64'h0000_0093);
        chk("c3_inst_pc", inst_pc, 64'h8000_0000);
        chk("c3_inst_fault", 64'(inst_fault), 64'd0);
        inst_ready = 1'b1;
        step();
        chk("c4_inst_valid", 64'(inst_valid), 64'd0);
        chk("c4_req_valid", 64'(imem_req_valid), 64'd1);
        chk("c4_req_addr", imem_req_addr, 64'h8000_0004);

        // back-pressure from decoder
        inst_ready = 1'b0;
        mem_data   = 32'h0010_0113;
        step();
        step();
        chk("bp_inst_valid", 64'(inst_valid), 64'd1);
        chk("bp_inst_pc", inst_pc, 64'h8000_0004);
        hold_instr = instruction;
        hold_pc    = inst_pc;
        fires0     = n_fire;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", 64'(inst_valid), 64'd1);
            chk("bp_hold_instr", 64'(instruction), 64'(hold_instr));
            chk("bp_hold_pc", inst_pc, hold_pc);
            chk("bp_no_req", 64'(imem_req_valid), 64'd0);
        end
        chk("bp_no_fire", 64'(n_fire), 64'(fires0));
        chk("bp_instr", 64'(hold_instr), 64'h0010_0113);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("bp_rel_valid", 64'(inst_valid), 64'd0);
        chk("bp_rel_addr", imem_req_addr, 64'h8000_0008);
        chk("bp_rel_req", 64'(imem_req_valid), 64'd1);

        // redirect during WAIT with 3-cycle latency
        mem_lat  = 3;
        mem_data = 32'hBAD0_0000;
        step();
        chk("rd_wait_req", 64'(imem_req_valid), 64'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        chk("rd_v0", 64'(inst_valid), 64'd0);
        step();
        chk("rd_rsp_seen", 64'(imem_rsp_valid), 64'd1);
        chk("rd_v1", 64'(inst_valid), 64'd0);
        step();
        chk("rd_dropped", 64'(inst_valid), 64'd0);
        chk("rd_req_valid", 64'(imem_req_valid), 64'd1);
        chk("rd_req_addr", imem_req_addr, 64'h8000_0100);
        mem_lat  = 1;
        mem_data = 32'h00A0_0513;
        step();
        step();
        chk("rd_deliv_valid", 64'(inst_valid), 64'd1);
        chk("rd_deliv_pc", inst_pc, 64'h8000_0100);
        chk("rd_deliv_instr", 64'(instruction), 64'h00A0_0513);

        // access fault response
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        mem_data   = 32'hDEAD_BEEF;
        mem_err    = 1'b1;
        chk("err_req_addr", imem_req_addr, 64'h8000_0104);
        step();
        step();
        mem_err = 1'b0;
        chk("err_valid", 64'(inst_valid), 64'd1);
        chk("err_fault", 64'(inst_fault), 64'd1);
        chk("err_instr", 64'(instruction), 64'hDEAD_BEEF);
        chk("err_pc", inst_pc, 64'h8000_0104);

        // misaligned redirect from HOLD
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
        chk("mis_squash", 64'(inst_valid), 64'd0);
        chk("mis_no_req", 64'(imem_req_valid), 64'd0);
        fires0 = n_fire;
        step();
        chk("mis_valid", 64'(inst_valid), 64'd1);
        chk("mis_instr", 64'(instruction), 64'h0000_0013);
        chk("mis_fault", 64'(inst_fault), 64'd1);
        chk("mis_pc", inst_pc, 64'h8000_0102);
        chk("mis_no_fire", 64'(n_fire), 64'(fires0));

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        chk("wrap_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        mem_data = 32'h0000_0073;
        step();
        step();
        chk("wrap_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_fault", 64'(inst_fault), 64'd0);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        chk("wrap_next_addr", imem_req_addr, 64'h0);
        chk("wrap_next_req", 64'(imem_req_valid), 64'd1);

        // reset asserted mid-WAIT
        mem_lat = 3;
        step();
        chk("mr_in_wait", 64'(imem_req_valid), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_inst_valid", 64'(inst_valid), 64'd0);
        chk("mr_instruction", 64'(instruction), 64'd0);
        chk("mr_inst_pc", inst_pc, 64'd0);
        chk("mr_req_valid", 64'(imem_req_valid), 64'd0);
        step();
        step();
        rst_n   = 1'b1;
        mem_lat = 1;
        mem_data = 32'h0000_0493;
        #1;
        chk("mr_restart_req", 64'(imem_req_valid), 64'd1);
        chk("mr_restart_addr", imem_req_addr, 64'h8000_0000);
        step();
        step();
        chk("mr_deliv_valid", 64'(inst_valid), 64'd1);
        chk("mr_deliv_pc", inst_pc, 64'h8000_0000);
        chk("mr_deliv_instr", 64'(instruction), 64'h0000_0493);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ysyx_22040729_ifu.md
Name: ysyx_22040729_ifu

Overview:
- Instruction fetch unit: the producer side of the decoder's instruction interface.
- Holds the PC and issues one 32-bit fetch at a time to instruction memory over a valid/ready request plus valid response channel.
- Presents each fetched word with its PC to the decoder over a valid/ready handshake.
- Accepts redirects (branch/jump/trap target) from execute; squashes stale fetches.

Parameters:
- INST_WIDTH, 32, instruction width.
- ADDR_WIDTH, 64, PC/address width.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  load redirect_pc as next fetch PC this cycle.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_WIDTH  fetch address (current PC).
- imem_rsp_valid  in  1  response valid, single-cycle pulse.
- imem_rsp_data  in  INST_WIDTH  fetched word.
- imem_rsp_err  in  1  access fault on this response.
- inst_valid  out  1  instruction available to decoder.
- inst_ready  in  1  decoder accepts instruction.
- instruction  out  INST_WIDTH  instruction word.
- inst_pc  out  ADDR_WIDTH  PC of the instruction.
- inst_fault  out  1  access fault or misaligned PC.

Behaviour:
- Reset while rst_n=0:
  - pc=RESET_PC, state=REQ, kill=0.
  - inst_valid=0, instruction=0, inst_pc=0, inst_fault=0.
  - imem_req_valid=0 is forced while rst_n is low.
- FSM states: REQ, WAIT, HOLD.
  - imem_req_valid = (state==REQ) && rst_n.
  - imem_req_addr = pc.
  - inst_valid, instruction, inst_pc and inst_fault are registers.
- REQ:
  - If redirect_valid: pc<=redirect_pc; stay REQ; the request in the same cycle is still offered with the old pc and, if accepted, kill<=1, go WAIT.
  - Else if imem_req_ready: go WAIT, kill<=0.
  - If pc[1:0]!=0, no request is issued (imem_req_valid=0). Next edge: load HOLD with instruction=32'h0000_0013, inst_fault=1, inst_pc=pc.
- WAIT:
  - On imem_rsp_valid with kill=1: drop the response, go REQ.
  - On imem_rsp_valid with kill=0: instruction<=imem_rsp_data, inst_pc<=pc, inst_fault<=imem_rsp_err, inst_valid<=1, go HOLD.
  - redirect_valid in WAIT: pc<=redirect_pc, kill<=1. The in-flight response is dropped.
  - Redirect in the same cycle as the response: response dropped, go REQ with the new pc.
- HOLD:
  - On inst_ready: inst_valid<=0, pc<=pc+4 (mod 2^ADDR_WIDTH, wraps to 0), go REQ.
  - On redirect_valid: inst_valid<=0, pc<=redirect_pc, go REQ. Redirect has priority over pc+4.
  - A handshake in that same cycle counts as accepted; downstream squashes it.
- Latency: request accepted at cycle N, response at N+k (k>=1), inst_valid high at N+k+1. After accept at cycle M, the next request is at M+1.
- At most one outstanding request.
- imem_rsp_valid in REQ or HOLD is ignored (protocol violation; assertion in bench).
- inst_valid stays high and the outputs stay stable until inst_ready or redirect.
- Reset mid-WAIT returns to the reset state. Memory shares rst_n, so no orphan response arrives.

Decomposition:
- Shared package: state encodings (REQ=2'd0, WAIT=2'd1, HOLD=2'd2), NOP constant 32'h0000_0013, RESET_PC default, INST_WIDTH/ADDR_WIDTH defaults shared with the decoder.
- No sub-module needed; state and pc registers may use the codebase's generic reset register block.

Test Plan:
- Release reset, memory ready=1, 1-cycle latency returning 32'h00000093 -> req addr 0x8000_0000 in the first cycle; inst_valid at cycle 3 with inst_pc=0x8000_0000. With inst_ready=1, the next req addr is 0x8000_0004.
- Hold inst_ready=0 for 5 cycles -> inst_valid, instruction and inst_pc stable; no new imem request. Assert inst_ready -> one transfer, then request at pc+4.
- Redirect to 0x8000_0100 while in WAIT with 3-cycle latency -> first response dropped, inst_valid stays 0; next req addr 0x8000_0100; delivered inst_pc=0x8000_0100.
- Response with imem_rsp_err=1 -> inst_fault=1 with that data. Redirect to 0x8000_0102 -> no imem request; instruction=0x00000013, inst_fault=1, inst_pc=0x8000_0102.
- PC wrap: redirect to 64'hFFFF_FFFF_FFFF_FFFC, accept -> next req addr 0.
- Assert rst_n low during WAIT -> outputs return to reset values asynchronously; after release, fetch restarts at 0x8000_0000.
